// File: rtl/mc_pkg.sv
//------------------------------------------------------------------------------
// Module   : mc_pkg
// Purpose  : Shared constants for the multicycle control unit: opcodes,
//            state encodings, ALU operation codes and datapath mux selects.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mc_pkg;

  // Opcodes understood by the control unit
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // State encodings, visible on state_o
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_IEXEC  = 4'd8;
  localparam logic [3:0] ST_IWB    = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;
  localparam logic [3:0] ST_JAL    = 4'd12;
  localparam logic [3:0] ST_TRAP   = 4'd13;

  typedef enum logic [3:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_MEMADR = ST_MEMADR,
    S_MEMRD  = ST_MEMRD,
    S_MEMWB  = ST_MEMWB,
    S_MEMWR  = ST_MEMWR,
    S_EXEC   = ST_EXEC,
    S_RWB    = ST_RWB,
    S_IEXEC  = ST_IEXEC,
    S_IWB    = ST_IWB,
    S_BRANCH = ST_BRANCH,
    S_JUMP   = ST_JUMP,
    S_JAL    = ST_JAL,
    S_TRAP   = ST_TRAP
  } state_t;

  // ALU control operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_FUNCT = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;

  // Register destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_opdecode.sv
//------------------------------------------------------------------------------
// Module   : mc_opdecode
// Purpose  : Combinational opcode classifier: maps an opcode to the state
//            that follows DECODE, the immediate extension mode and legality.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_opdecode
  import mc_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] op,
  output state_t          next_class,
  output logic            ext_mode,
  output logic            is_legal
);

  // Opcode table; anything not listed is classified as a trap
  always_comb begin
    next_class = S_TRAP;
    ext_mode   = 1'b0;
    is_legal   = 1'b1;
    case (op)
      OP_W'(OP_RTYPE): next_class = S_EXEC;
      OP_W'(OP_LW):    next_class = S_MEMADR;
      OP_W'(OP_SW):    next_class = S_MEMADR;
      OP_W'(OP_BEQ):   next_class = S_BRANCH;
      OP_W'(OP_J):     next_class = S_JUMP;
      OP_W'(OP_JAL):   next_class = S_JAL;
      OP_W'(OP_ADDI): begin
        next_class = S_IEXEC;
        ext_mode   = 1'b1;
      end
      OP_W'(OP_ORI):   next_class = S_IEXEC;
      default: begin
        next_class = S_TRAP;
        is_legal   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Purpose  : Multicycle main control FSM. Sequences each instruction over
//            3-5 cycles with memory-ready stalls and an illegal-opcode trap.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mc_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int ALUOP_W   = 4,
  parameter int TRAP_HOLD = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               pc_to_reg,
  output logic               ext_mode,
  output logic [1:0]         reg_dst,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal,
  output logic [3:0]         state_o
);

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic            ext_q;

  state_t          dec_class;
  logic            dec_ext;
  logic            dec_legal;

  mc_opdecode #(.OP_W(OP_W)) u_opdecode (
    .op         (op),
    .next_class (dec_class),
    .ext_mode   (dec_ext),
    .is_legal   (dec_legal)
  );

  // The zero flag is consumed by the datapath through pc_write_cond
  logic unused_zero;
  assign unused_zero = zero;

  // State register plus opcode/extension latch captured in DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      op_q  <= '0;
      ext_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:  state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          state <= dec_legal ? dec_class : S_TRAP;
          op_q  <= op;
          ext_q <= dec_ext;
        end
        S_MEMADR: state <= (op_q == OP_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:   state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_IEXEC:  state <= S_IWB;
        S_IWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_JAL:    state <= S_FETCH;
        S_TRAP:   state <= (TRAP_HOLD != 0) ? S_TRAP : S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from the current state (FETCH strobes are Mealy)
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    pc_to_reg     = 1'b0;
    ext_mode      = 1'b0;
    reg_dst       = RD_RT;
    alu_src_b     = SRCB_B;
    pc_src        = PCSRC_ALU;
    alu_op        = ALUOP_W'(ALU_ADD);
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        ext_mode  = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_mode  = 1'b1;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALU_FUNCT);
      end
      S_RWB: begin
        reg_dst   = RD_RD;
        reg_write = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ext_mode  = ext_q;
        alu_op    = (op_q == OP_W'(OP_ORI)) ? ALUOP_W'(ALU_OR) : ALUOP_W'(ALU_ADD);
      end
      S_IWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALU_SUB);
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src    = PCSRC_JUMP;
        pc_write  = 1'b1;
        reg_dst   = RD_RA;
        pc_to_reg = 1'b1;
        reg_write = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control with randomized
//            instruction streams, stalls and directed corner cases.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;
  import mc_pkg::*;

  typedef logic [3:0] st_q_t[$];

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       zero;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_write, alu_src_a, pc_to_reg, ext_mode;
  logic [1:0] reg_dst, alu_src_b, pc_src;
  logic [3:0] alu_op;
  logic       illegal;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_control #(.OP_W(6), .ALUOP_W(4), .TRAP_HOLD(1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .pc_to_reg(pc_to_reg), .ext_mode(ext_mode), .reg_dst(reg_dst),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .illegal(illegal), .state_o(state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [25:0] obs;
  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_write, alu_src_a, pc_to_reg, ext_mode,
                reg_dst, alu_src_b, pc_src, alu_op, illegal, state_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Instruction -> sequence of states it walks through (from the opcode table)
  function automatic st_q_t seq_of(input logic [5:0] o);
    case (o)
      OP_LW:          return '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMRD, ST_MEMWB};
      OP_SW:          return '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWR};
      OP_RTYPE:       return '{ST_FETCH, ST_DECODE, ST_EXEC, ST_RWB};
      OP_ADDI, OP_ORI: return '{ST_FETCH, ST_DECODE, ST_IEXEC, ST_IWB};
      OP_BEQ:         return '{ST_FETCH, ST_DECODE, ST_BRANCH};
      OP_J:           return '{ST_FETCH, ST_DECODE, ST_JUMP};
      OP_JAL:         return '{ST_FETCH, ST_DECODE, ST_JAL};
      default:        return '{ST_FETCH, ST_DECODE, ST_TRAP};
    endcase
  endfunction

  function automatic bit is_wait(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

  // Expected control word for a state, the instruction in flight and mem_ready
  function automatic logic [25:0] exp_vec(input logic [3:0] s, input logic [5:0] o, input logic mr);
    logic pw = 0, pwc = 0, io = 0, mrd = 0, mw = 0, irw = 0, m2r = 0, rw = 0;
    logic sa = 0, p2r = 0, ext = 0, ill = 0;
    logic [1:0] rd = 0, sb = 0, ps = 0;
    logic [3:0] ao = 0;
    case (s)
      ST_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
      ST_DECODE: begin sb = 2'b11; ext = 1; end
      ST_MEMADR: begin sa = 1; sb = 2'b10; ext = 1; end
      ST_MEMRD:  begin io = 1; mrd = 1; end
      ST_MEMWB:  begin m2r = 1; rw = 1; end
      ST_MEMWR:  begin io = 1; mw = 1; end
      ST_EXEC:   begin sa = 1; ao = 4'd2; end
      ST_RWB:    begin rd = 2'b01; rw = 1; end
      ST_IEXEC:  begin sa = 1; sb = 2'b10; ao = (o == OP_ORI) ? 4'd3 : 4'd0; ext = (o == OP_ADDI); end
      ST_IWB:    begin rw = 1; end
      ST_BRANCH: begin sa = 1; ao = 4'd1; ps = 2'b01; pwc = 1; end
      ST_JUMP:   begin ps = 2'b10; pw = 1; end
      ST_JAL:    begin ps = 2'b10; pw = 1; rd = 2'b10; p2r = 1; rw = 1; end
      ST_TRAP:   begin ill = 1; end
      default: ;
    endcase
    return {pw, pwc, io, mrd, mw, irw, m2r, rw, sa, p2r, ext, rd, sb, ps, ao, ill, s};
  endfunction

  // One clock: drive inputs just after the edge, then compare settled outputs
  task automatic step(input logic r, input logic mr, input logic z, input logic [5:0] o,
                      input logic [3:0] es, input logic [5:0] eop, input string tag);
    @(posedge clk);
    #1;
    reset = r; mem_ready = mr; zero = z; op = o;
    #1;
    check(tag, 32'(obs), 32'(exp_vec(es, eop, mr)));
    check({tag, "_excl"}, {30'd0, mem_write & reg_write, pc_write & pc_write_cond}, 32'd0);
  endtask

  // plan < 0: random stalls; plan >= 0: FETCH ready, exactly plan stalls in MEMRD/MEMWR
  task automatic run_instr(input logic [5:0] opc, input int plan, input int zsel, output int cycles);
    st_q_t sq;
    int nst;
    logic mr, z;
    logic [5:0] o;
    logic [3:0] s;
    sq = seq_of(opc);
    cycles = 0;
    foreach (sq[i]) begin
      s = sq[i];
      nst = 0;
      forever begin
        if (is_wait(s)) begin
          if (plan < 0)            mr = ($urandom_range(0, 3) != 0) || (nst >= 3);
          else if (s == ST_FETCH)  mr = 1'b1;
          else                     mr = (nst >= plan);
        end else begin
          mr = 1'($urandom_range(0, 1));
        end
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        o = (s == ST_DECODE) ? opc : 6'($urandom_range(0, 63));
        step(1'b0, mr, z, o, s, opc, $sformatf("op%b_st%0d", opc, s));
        cycles++;
        if (!is_wait(s) || mr) break;
        nst++;
      end
    end
  endtask

  logic [5:0] legal_ops [8] = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_ORI};

  initial begin
    int cyc;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = 6'd0;
    @(posedge clk);
    step(1'b1, 1'b1, 1'b0, 6'd0, ST_FETCH, 6'd0, "reset");

    // Directed: lw with two MEMRD stalls takes 7 cycles
    run_instr(OP_LW, 2, -1, cyc);
    check("lw_latency", 32'(cyc), 32'd7);

    // Directed: beq with zero low then high
    run_instr(OP_BEQ, 0, 0, cyc);
    check("beq_z0_latency", 32'(cyc), 32'd3);
    run_instr(OP_BEQ, 0, 1, cyc);
    check("beq_z1_latency", 32'(cyc), 32'd3);

    // Directed: jal, sw, addi, ori
    run_instr(OP_JAL, 0, -1, cyc);
    check("jal_latency", 32'(cyc), 32'd3);
    run_instr(OP_SW, 0, -1, cyc);
    check("sw_latency", 32'(cyc), 32'd4);
    run_instr(OP_ADDI, 0, -1, cyc);
    run_instr(OP_ORI, 0, -1, cyc);
    check("ori_latency", 32'(cyc), 32'd4);

    // Random instruction stream with random stalls and junk on op after DECODE
    for (int n = 0; n < 60; n++) begin
      run_instr(legal_ops[$urandom_range(0, 7)], -1, -1, cyc);
    end

    // Reset while stalled in MEMWR
    step(1'b0, 1'b1, 1'b0, 6'h15, ST_FETCH,  OP_SW, "swr_fetch");
    step(1'b0, 1'b0, 1'b0, OP_SW, ST_DECODE, OP_SW, "swr_decode");
    step(1'b0, 1'b0, 1'b0, 6'h2a, ST_MEMADR, OP_SW, "swr_memadr");
    step(1'b0, 1'b0, 1'b0, 6'h2a, ST_MEMWR,  OP_SW, "swr_stall");
    step(1'b1, 1'b0, 1'b0, 6'h2a, ST_MEMWR,  OP_SW, "swr_rst");
    step(1'b0, 1'b0, 1'b0, 6'h2a, ST_FETCH,  OP_SW, "swr_after");
    check("swr_mem_write", {31'd0, mem_write}, 32'd0);

    // Illegal opcode: sticky trap, then reset recovers
    run_instr(6'b111111, 0, -1, cyc);
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), ST_TRAP, 6'b111111, "trap_hold");
    end
    step(1'b1, 1'b1, 1'b0, 6'd0, ST_TRAP, 6'b111111, "trap_rst");
    run_instr(OP_RTYPE, 0, -1, cyc);
    check("rtype_after_trap", 32'(cyc), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multicycle successor to the single-cycle main decoder: a Moore/Mealy FSM sequencing each instruction over 3–5 cycles.
- Sits between the instruction register opcode field and the shared-memory multicycle datapath (PC, IR, MDR, A/B, ALUOut).
- Adds a memory ready handshake with stall, support for beq, addi, ori and jal, and an illegal-opcode trap.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 4, width of alu_op to the ALU control.
- TRAP_HOLD, 1, 1 = trap state is sticky until reset; 0 = return to FETCH after one cycle.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  OP_W  opcode from the instruction register; sampled in DECODE.
- mem_ready  in  1  memory access completes this cycle.
- zero  in  1  ALU zero flag.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_to_reg, ext_mode  out  1 each  datapath controls.
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext imm, 11 = ext imm << 2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  out  ALUOP_W  0 = add, 1 = sub, 2 = R-type funct, 3 = or.
- illegal  out  1  high while in TRAP.
- state_o  out  4  current state, for debug.

Behaviour:
- Reset: synchronous reset forces state FETCH. All outputs are decoded from state, so the FETCH values below apply during reset and on the first cycle after it.
- Outputs not listed for a state are 0. None are X; unused selects are 0.
- Opcode decode in DECODE:
  - R-type 000000 -> EXEC
  - lw 100011, sw 101011 -> MEMADR
  - beq 000100 -> BRANCH
  - j 000010 -> JUMP
  - jal 000011 -> JAL
  - addi 001000 -> IEXEC, with ext_mode = 1 (sign extend)
  - ori 001101 -> IEXEC, with ext_mode = 0 (zero extend)
  - any other opcode -> TRAP
- Per-state outputs and transitions:
  - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00. ir_write and pc_write equal mem_ready (Mealy). Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target precomputed), ext_mode=1. Next state from the decode table above.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add, ext_mode=1. Go to MEMRD if op=lw, else MEMWR.
  - MEMRD: iord=1, mem_read=1. Stay until mem_ready, then go to MEMWB.
  - MEMWB: reg_dst=00, mem_to_reg=1, reg_write=1. Go to FETCH.
  - MEMWR: iord=1, mem_write=1. Stay until mem_ready, then go to FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=R-type funct. Go to RWB.
  - RWB: reg_dst=01, reg_write=1. Go to FETCH.
  - IEXEC: alu_src_a=1, alu_src_b=10, alu_op = add for addi, or for ori. Go to IWB.
  - IWB: reg_dst=00, reg_write=1. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, pc_write_cond=1 (PC loads only when zero=1). Go to FETCH.
  - JUMP: pc_src=10, pc_write=1. Go to FETCH.
  - JAL: pc_src=10, pc_write=1, reg_dst=10, pc_to_reg=1, reg_write=1. Go to FETCH.
  - TRAP: illegal=1, no writes. Held in TRAP if TRAP_HOLD=1; otherwise go to FETCH next cycle.
- Opcode latching: op is latched into an internal register in DECODE. MEMADR and IEXEC use the latched value, so a change on op after DECODE has no effect.
- Write ordering: mem_write and reg_write are never both 1 in the same cycle. pc_write and pc_write_cond are never both 1 in the same cycle.
- Reset mid-operation, including during a stall: next state is FETCH, and no write strobe is asserted in the cycle after reset.
- Latency (cycles, excluding stalls): lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3, jal 3. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants
  - state encodings (4-bit localparams)
  - alu_op codes
  - reg_dst, alu_src_b and pc_src select encodings
- One natural sub-module, mc_opdecode: combinational op -> {next-state class, ext_mode, is_legal}. It is reused by any later pipelined control.

Test Plan:
- Reset for 2 cycles, release, mem_ready=1 -> FETCH with mem_read=1, ir_write=1, pc_write=1; state_o = DECODE the next cycle.
- lw (op=100011) with mem_ready low for 2 cycles in MEMRD -> 7 cycles FETCH-to-FETCH; reg_write=1 and mem_to_reg=1 in MEMWB only.
- beq with zero=0, then with zero=1 -> pc_write_cond=1 in BRANCH both times, alu_op=sub; back to FETCH after 3 cycles.
- jal (000011) -> JAL cycle with reg_dst=10, pc_to_reg=1, pc_src=10, pc_write=1, reg_write=1.
- op=111111 with TRAP_HOLD=1 -> illegal=1 held for 10+ cycles with all writes 0; reset -> FETCH.
- Assert reset while stalled in MEMWR with mem_ready=0 -> FETCH next cycle; mem_write=0 from the cycle after reset.
